flatten_pingpong_buffer: RTL and testbench

Parametrised, double-buffered successor to the single-frame flatten stage between the last conv/pool stage and the fully-connected layer. Serial feature words fill one bank while the other, completed bank is read by the FC engine through an addressed, registered read port. A frame release hands the bank back, so conv output and FC compute overlap without stalling. Back-pressure, sticky overflow, frame-done pulse and synchronous clear are added over the single-shot flatten.

---
 rtl/npu_pkg.sv | 10 +
 rtl/flatten_pingpong_buffer_if.sv | 30 +++
 rtl/flatten_bank_ram.sv | 39 +++
 rtl/flatten_pingpong_buffer.sv | 116 +++++++++++
 tb/tb_flatten_pingpong_buffer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/npu_pkg.sv
// Shared NPU types and sizing for the flatten / FC boundary.
package npu_pkg;
  localparam int unsigned FEAT_W     = 22;
  localparam int unsigned FLAT_DEPTH = 225;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_t;
endpackage

// File: rtl/flatten_pingpong_buffer_if.sv
// Feature write stream, status flags and FC read port of the ping-pong flatten buffer.
interface flatten_pingpong_buffer_if #(
  parameter int unsigned DATA_W = npu_pkg::FEAT_W,
  parameter int unsigned DEPTH  = npu_pkg::FLAT_DEPTH
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic                     i_clear;
  logic                     i_data_valid;
  logic signed [DATA_W-1:0] i_data_in;
  logic                     o_in_ready;
  logic [ADDR_W:0]          o_fill_count;
  logic                     o_overflow;
  logic                     o_frame_done;
  logic                     o_out_valid;
  logic                     i_rd_en;
  logic [ADDR_W-1:0]        i_rd_addr;
  logic signed [DATA_W-1:0] o_rd_data;
  logic                     i_release;

  modport master (
    output i_clear, i_data_valid, i_data_in, i_rd_en, i_rd_addr, i_release,
    input  o_in_ready, o_fill_count, o_overflow, o_frame_done, o_out_valid, o_rd_data
  );

  modport slave (
    input  i_clear, i_data_valid, i_data_in, i_rd_en, i_rd_addr, i_release,
    output o_in_ready, o_fill_count, o_overflow, o_frame_done, o_out_valid, o_rd_data
  );
endinterface

// File: rtl/flatten_bank_ram.sv
// One frame bank: single write port, registered read port returning 0 past DEPTH-1.
module flatten_bank_ram #(
  parameter int unsigned DATA_W = 22,
  parameter int unsigned DEPTH  = 225,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data
);
  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic signed [DATA_W-1:0] rd_data_q;
  logic signed [DATA_W-1:0] rd_data_d;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if ({1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH)) rd_data_d = mem_q[rd_addr];
      else                                          rd_data_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/flatten_pingpong_buffer.sv
// Double-buffered flatten stage: one bank fills from the conv stream while the FC engine reads the other.
module flatten_pingpong_buffer
  import npu_pkg::*;
#(
  parameter int unsigned DATA_W = FEAT_W,
  parameter int unsigned DEPTH  = FLAT_DEPTH
) (
  input logic                 clk,
  input logic                 rst,
  flatten_pingpong_buffer_if.slave bus
);
  localparam int unsigned       ADDR_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  bank_state_t [1:0]  state_q, state_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic               rd_sel_q, rd_sel_d;
  logic [ADDR_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic               overflow_q, overflow_d;
  logic               frame_done_q, frame_done_d;

  logic               in_ready_c, out_valid_c, accept_c;
  logic               we0_c, we1_c;
  logic signed [DATA_W-1:0] rd0_data, rd1_data;

  assign in_ready_c  = (state_q[wr_bank_q] == BANK_EMPTY);
  assign out_valid_c = (state_q[rd_bank_q] == BANK_FULL);
  assign accept_c    = bus.i_data_valid && in_ready_c;
  assign we0_c       = accept_c && !bus.i_clear && !wr_bank_q;
  assign we1_c       = accept_c && !bus.i_clear &&  wr_bank_q;

  // Completion and release always touch different banks, so both may apply in one cycle.
  always_comb begin
    state_d      = state_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_cnt_d     = wr_cnt_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;
    rd_sel_d     = bus.i_rd_en ? rd_bank_q : rd_sel_q;
    if (bus.i_clear) begin
      state_d    = {BANK_EMPTY, BANK_EMPTY};
      wr_bank_d  = 1'b0;
      rd_bank_d  = 1'b0;
      wr_cnt_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (accept_c) begin
        if (wr_cnt_q == LAST_IDX) begin
          state_d[wr_bank_q] = BANK_FULL;
          wr_bank_d          = ~wr_bank_q;
          wr_cnt_d           = '0;
          frame_done_d       = 1'b1;
        end else begin
          wr_cnt_d = wr_cnt_q + ADDR_W'(1);
        end
      end
      if (bus.i_data_valid && !in_ready_c) overflow_d = 1'b1;
      if (bus.i_release && out_valid_c) begin
        state_d[rd_bank_q] = BANK_EMPTY;
        rd_bank_d          = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= {BANK_EMPTY, BANK_EMPTY};
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      rd_sel_q     <= 1'b0;
      wr_cnt_q     <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      rd_sel_q     <= rd_sel_d;
      wr_cnt_q     <= wr_cnt_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  flatten_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .we      (we0_c),
    .wr_addr (wr_cnt_q),
    .wr_data (bus.i_data_in),
    .rd_en   (bus.i_rd_en),
    .rd_addr (bus.i_rd_addr),
    .rd_data (rd0_data)
  );

  flatten_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .we      (we1_c),
    .wr_addr (wr_cnt_q),
    .wr_data (bus.i_data_in),
    .rd_en   (bus.i_rd_en),
    .rd_addr (bus.i_rd_addr),
    .rd_data (rd1_data)
  );

  // Bank select is captured with the read so a later release cannot retarget held data.
  assign bus.o_rd_data    = rd_sel_q ? rd1_data : rd0_data;
  assign bus.o_in_ready   = in_ready_c;
  assign bus.o_out_valid  = out_valid_c;
  assign bus.o_fill_count = {1'b0, wr_cnt_q};
  assign bus.o_overflow   = overflow_q;
  assign bus.o_frame_done = frame_done_q;
endmodule

// File: tb/tb_flatten_pingpong_buffer.sv
// Directed checks of the ping-pong flatten buffer at DEPTH=8 and at the default 225-word frame.
module tb_flatten_pingpong_buffer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  flatten_pingpong_buffer_if #(.DATA_W(22), .DEPTH(8)) bus8 ();
  flatten_pingpong_buffer_if bus_d ();

  flatten_pingpong_buffer #(.DATA_W(22), .DEPTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  flatten_pingpong_buffer dut_d (
    .clk (clk),
    .rst (rst),
    .bus (bus_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed8(input int v);
    bus8.i_data_valid = 1'b1;
    bus8.i_data_in    = 22'(v);
    step();
    bus8.i_data_valid = 1'b0;
  endtask

  task automatic rd8(input int a);
    bus8.i_rd_en   = 1'b1;
    bus8.i_rd_addr = 3'(a);
    step();
    bus8.i_rd_en   = 1'b0;
  endtask

  task automatic rel8();
    bus8.i_release = 1'b1;
    step();
    bus8.i_release = 1'b0;
  endtask

  task automatic rdd(input int a);
    bus_d.i_rd_en   = 1'b1;
    bus_d.i_rd_addr = 8'(a);
    step();
    bus_d.i_rd_en   = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus8.i_clear = 1'b0; bus8.i_data_valid = 1'b0; bus8.i_data_in = '0;
    bus8.i_rd_en = 1'b0; bus8.i_rd_addr = '0; bus8.i_release = 1'b0;
    bus_d.i_clear = 1'b0; bus_d.i_data_valid = 1'b0; bus_d.i_data_in = '0;
    bus_d.i_rd_en = 1'b0; bus_d.i_rd_addr = '0; bus_d.i_release = 1'b0;
    step();
    step();

    check("rst_in_ready",   bus8.o_in_ready,   1);
    check("rst_fill",       bus8.o_fill_count, 0);
    check("rst_overflow",   bus8.o_overflow,   0);
    check("rst_frame_done", bus8.o_frame_done, 0);
    check("rst_out_valid",  bus8.o_out_valid,  0);
    check("rst_rd_data",    bus8.o_rd_data,    0);
    rst = 1'b0;
    step();

    // Frame 1..8 back-to-back, then one-cycle-latency readback
    for (int i = 1; i <= 8; i++) begin
      feed8(i);
      if (i == 3) check("t1_fill3", bus8.o_fill_count, 3);
      if (i < 8)  check("t1_not_valid", bus8.o_out_valid, 0);
    end
    check("t1_frame_done", bus8.o_frame_done, 1);
    check("t1_out_valid",  bus8.o_out_valid,  1);
    check("t1_fill0",      bus8.o_fill_count, 0);
    check("t1_in_ready",   bus8.o_in_ready,   1);
    step();
    check("t1_done_low",   bus8.o_frame_done, 0);
    for (int a = 0; a < 8; a++) begin
      rd8(a);
      check("t1_rd", bus8.o_rd_data, a + 1);
    end
    step();
    check("t1_rd_hold", bus8.o_rd_data, 8);
    rel8();
    check("t1_rel_valid", bus8.o_out_valid, 0);
    check("t1_rel_ready", bus8.o_in_ready,  1);

    // Two frames without release, overflow on the 17th word
    for (int i = 1; i <= 16; i++) feed8(i);
    check("t2_in_ready_low", bus8.o_in_ready,   0);
    check("t2_out_valid",    bus8.o_out_valid,  1);
    check("t2_frame_done",   bus8.o_frame_done, 1);
    feed8(99);
    check("t2_overflow", bus8.o_overflow,   1);
    check("t2_fill0",    bus8.o_fill_count, 0);
    rel8();
    check("t2_valid_kept", bus8.o_out_valid, 1);
    check("t2_ready_back", bus8.o_in_ready,  1);
    for (int a = 0; a < 8; a++) begin
      rd8(a);
      check("t2_rd_frame2", bus8.o_rd_data, a + 9);
    end

    // Release on the same edge as the next frame completes
    for (int i = 31; i <= 37; i++) begin
      feed8(i);
      check("t3_valid_cont", bus8.o_out_valid, 1);
    end
    bus8.i_release = 1'b1;
    feed8(38);
    bus8.i_release = 1'b0;
    check("t3_valid_cont_end", bus8.o_out_valid,  1);
    check("t3_in_ready",       bus8.o_in_ready,   1);
    check("t3_frame_done",     bus8.o_frame_done, 1);
    rd8(0);
    check("t3_rd0", bus8.o_rd_data, 31);
    rd8(7);
    check("t3_rd7", bus8.o_rd_data, 38);
    rel8();
    check("t3_empty", bus8.o_out_valid, 0);

    // Clear with a full bank, a partial frame and sticky overflow set
    check("t4_ovf_sticky", bus8.o_overflow, 1);
    for (int i = 50; i <= 57; i++) feed8(i);
    for (int i = 40; i <= 44; i++) feed8(i);
    check("t4_fill5",  bus8.o_fill_count, 5);
    check("t4_valid1", bus8.o_out_valid,  1);
    bus8.i_clear = 1'b1;
    step();
    bus8.i_clear = 1'b0;
    check("t4_clr_fill",     bus8.o_fill_count, 0);
    check("t4_clr_overflow", bus8.o_overflow,   0);
    check("t4_clr_valid",    bus8.o_out_valid,  0);
    check("t4_clr_ready",    bus8.o_in_ready,   1);
    for (int i = 21; i <= 28; i++) feed8(i);
    check("t4_valid_new", bus8.o_out_valid, 1);
    for (int a = 0; a < 8; a++) begin
      rd8(a);
      check("t4_rd", bus8.o_rd_data, a + 21);
    end

    // Asynchronous reset mid-cycle, mid-frame
    for (int i = 60; i <= 62; i++) feed8(i);
    check("t5_fill3", bus8.o_fill_count, 3);
    #3;
    rst = 1'b1;
    #1;
    check("t5_async_fill",     bus8.o_fill_count, 0);
    check("t5_async_valid",    bus8.o_out_valid,  0);
    check("t5_async_ready",    bus8.o_in_ready,   1);
    check("t5_async_rd_data",  bus8.o_rd_data,    0);
    check("t5_async_overflow", bus8.o_overflow,   0);
    check("t5_async_done",     bus8.o_frame_done, 0);
    #2;
    rst = 1'b0;
    step();

    // Default geometry: signed words -112..112, out-of-range read, ignored release
    bus_d.i_release = 1'b1;
    step();
    bus_d.i_release = 1'b0;
    check("t6_idle_valid", bus_d.o_out_valid, 0);
    check("t6_idle_ready", bus_d.o_in_ready,  1);
    for (int v = -112; v <= 112; v++) begin
      bus_d.i_data_valid = 1'b1;
      bus_d.i_data_in    = 22'(v);
      step();
    end
    bus_d.i_data_valid = 1'b0;
    check("t6_frame_done", bus_d.o_frame_done, 1);
    check("t6_out_valid",  bus_d.o_out_valid,  1);
    rdd(0);
    check("t6_rd0", bus_d.o_rd_data, -112);
    rdd(112);
    check("t6_rd112", bus_d.o_rd_data, 0);
    rdd(224);
    check("t6_rd224", bus_d.o_rd_data, 112);
    rdd(1);
    check("t6_rd1", bus_d.o_rd_data, -111);
    rdd(240);
    check("t6_rd_oob", bus_d.o_rd_data, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
